// File: rtl/memoria_resp.sv
// Word-addressed memory responder: accepts one read/write, inserts WAIT_STATES waits, then pulses Ready.
// Optional feature macro: MEMRESP_BACK2BACK_EN (accept a new Req during RESP).
module memoria_resp #(
  parameter int ADDR_WORDS  = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Req,
  input  logic        CtrMem,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        Ready,
  output logic        Busy,
  output logic        ReqDrop
);

  localparam int IW = $clog2(ADDR_WORDS);
  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic            wr_q;
  logic [IW-1:0]   idx_q;
  logic [31:0]     data_q;
  logic [IW-1:0]   in_idx;
  logic [IW-1:0]   rd_idx;
  logic [31:0]     rd_word;
  logic            rd_next;
  logic            can_accept;
  logic            accept;
  logic [31:0]     mem [ADDR_WORDS];

  assign in_idx = Address[IW+1:2];

  logic addr_unused;
  assign addr_unused = ^{Address[31:IW+2], Address[1:0]};

`ifdef MEMRESP_BACK2BACK_EN
  assign can_accept = (state == S_IDLE) || (state == S_RESP);
`else
  assign can_accept = (state == S_IDLE);
`endif
  assign accept = Req && can_accept;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (accept) state_n = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (cnt == CW'(1)) state_n = S_RESP;
      S_RESP: begin
        if (accept) state_n = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
        else        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // The access entering RESP is the latched one when leaving WAIT, otherwise the one accepted now.
  always_comb begin
    rd_idx  = (state == S_WAIT) ? idx_q : in_idx;
    rd_next = (state == S_WAIT) ? !wr_q : !CtrMem;
    rd_word = mem[rd_idx];
    // A back-to-back read of the word being written on this same edge sees the new data.
    if (state == S_RESP && wr_q && idx_q == rd_idx) rd_word = data_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      DataOut <= '0;
      Ready   <= 1'b0;
      Busy    <= 1'b0;
      ReqDrop <= 1'b0;
    end else begin
      state   <= state_n;
      Busy    <= (state_n != S_IDLE);
      Ready   <= (state_n == S_RESP);
      ReqDrop <= Req && !can_accept;
      if (accept) begin
        wr_q   <= CtrMem;
        idx_q  <= in_idx;
        data_q <= DataIn;
        cnt    <= CW'(WAIT_STATES);
      end else if (state == S_WAIT) begin
        cnt <= cnt - CW'(1);
      end
      if (state_n == S_RESP && rd_next) DataOut <= rd_word;
    end
  end

  // NOTE: storage has no reset; an asserted Reset already forces state to IDLE, which blocks an aborted write.
  always_ff @(posedge Clock) begin
    if (state == S_RESP && wr_q) mem[idx_q] <= data_q;
  end

endmodule
